// File: rtl/mem_block_engine.sv
// ---------------------------------------------------------------------------
// mem_block_engine
//
// Requester-side block engine for the 32K x 64 internal memory port.
// Runs one of three block operations per accepted START:
//    FILL  - write PATTERN to LEN consecutive words starting at DST
//    COPY  - read SRC+i, then write that word to DST+i, one word per 2 cycles
//    CHECK - pipelined reads of SRC+i, counting words that differ from PATTERN
// Read responses carry back the request tag, which is checked against the
// address that was actually requested.
//
// Ports
//    CLK                 clock, rising edge
//    RESET               synchronous reset, active low
//    START/OP            command strobe and opcode (00 FILL, 01 COPY, 10 CHECK)
//    SRC/DST/LEN         block source, destination (word addr) and word count
//    PATTERN             fill data / check compare value
//    BUSY/DONE/ERR       status: running, one-cycle completion, error flag
//    MISMATCH            saturating CHECK miscompare count
//    ACT/CMD/ADDR/BE/DI  memory request (CMD 1=read, BE active low)
//    TI                  request tag
//    DRDY/DO/TO          read response (valid one cycle after the read)
// ---------------------------------------------------------------------------
//  state       | meaning
//  ------------+-------------------------------------------------------------
//  S_IDLE      | waiting for START
//  S_FILL      | one pattern write per cycle
//  S_COPY_RD   | read request for the current COPY word
//  S_COPY_WR   | write of the returned word (suppressed on a bad response)
//  S_CHK       | one read per cycle, responses checked one cycle later
//  S_CHK_DRAIN | no request, checks the response to the last read
//  S_FIN       | one-cycle DONE pulse, BUSY low
// ---------------------------------------------------------------------------
module mem_block_engine #(
   parameter int TagWidth = 21
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                START,
   input  logic [1:0]          OP,
   input  logic [14:0]         SRC,
   input  logic [14:0]         DST,
   input  logic [15:0]         LEN,
   input  logic [63:0]         PATTERN,
   output logic                BUSY,
   output logic                DONE,
   output logic                ERR,
   output logic [15:0]         MISMATCH,
   output logic                ACT,
   output logic                CMD,
   output logic [14:0]         ADDR,
   output logic [7:0]          BE,
   output logic [63:0]         DI,
   output logic [TagWidth-1:0] TI,
   input  logic                DRDY,
   input  logic [63:0]         DO,
   input  logic [TagWidth-1:0] TO
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_COPY_RD,
      S_COPY_WR,
      S_CHK,
      S_CHK_DRAIN,
      S_FIN
   } state_t;

   localparam logic [1:0] OP_FILL = 2'b00;
   localparam logic [1:0] OP_COPY = 2'b01;
   localparam logic [1:0] OP_RSVD = 2'b11;

   state_t                state;
   logic                  act_r;
   logic                  cmd_r;
   logic [14:0]           addr_r;
   logic [7:0]            be_r;
   logic [63:0]           di_r;
   logic [TagWidth-1:0]   ti_r;
   logic                  busy_r;
   logic                  done_r;
   logic                  err_r;
   logic [15:0]           mis_r;

   logic [14:0]           src_ptr;
   logic [14:0]           dst_ptr;
   logic [14:0]           src_nxt;
   logic [14:0]           dst_nxt;
   logic [15:0]           remaining;     // words left after the current one
   logic [63:0]           pattern_r;
   logic                  rd_pend;       // a CHECK read was issued last cycle
   logic [14:0]           rd_addr;       // address of that read

   logic                  rsp_ok;
   logic                  wr_blocked;
   logic                  rsp_check;
   logic                  last_word;
   logic                  unused_to;

   function automatic logic [TagWidth-1:0] rd_tag(input logic [14:0] a);
      logic [TagWidth-1:0] t;
      t = '0;
      t[TagWidth-1] = 1'b1;
      t[14:0] = a;
      return t;
   endfunction

   assign src_nxt   = src_ptr + 15'd1;
   assign dst_nxt   = dst_ptr + 15'd1;
   assign last_word = (remaining == 16'd0);

   // The COPY write may only go out if the word it carries is the one we
   // asked for; otherwise the request is squashed in the same cycle.
   assign rsp_ok     = DRDY && (TO[14:0] == src_ptr);
   assign wr_blocked = (state == S_COPY_WR) && !rsp_ok;
   assign rsp_check  = (state == S_CHK) || (state == S_CHK_DRAIN);

   // Only the low 15 tag bits identify the request.
   assign unused_to = ^TO[TagWidth-1:15];

   assign ACT      = act_r && !wr_blocked;
   assign CMD      = cmd_r;
   assign ADDR     = addr_r;
   assign BE       = be_r;
   assign DI       = (state == S_COPY_WR) ? DO : di_r;
   assign TI       = ti_r;
   assign BUSY     = busy_r;
   assign DONE     = done_r;
   assign ERR      = err_r;
   assign MISMATCH = mis_r;

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state     <= S_IDLE;
         act_r     <= 1'b0;
         cmd_r     <= 1'b0;
         addr_r    <= '0;
         be_r      <= 8'hFF;
         di_r      <= '0;
         ti_r      <= '0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         err_r     <= 1'b0;
         mis_r     <= '0;
         src_ptr   <= '0;
         dst_ptr   <= '0;
         remaining <= '0;
         pattern_r <= '0;
         rd_pend   <= 1'b0;
         rd_addr   <= '0;
      end else begin
         done_r <= 1'b0;

         // CHECK response path: the response to the read of the previous
         // cycle is due now.
         if (rsp_check) begin
            if (DRDY && (DO != pattern_r) && (mis_r != 16'hFFFF)) begin
               mis_r <= mis_r + 16'd1;
            end
            if (rd_pend && (!DRDY || (TO[14:0] != rd_addr))) begin
               err_r <= 1'b1;
            end
         end

         case (state)
            S_IDLE, S_FIN: begin
               state  <= S_IDLE;
               busy_r <= 1'b0;
               act_r  <= 1'b0;
               cmd_r  <= 1'b0;
               be_r   <= 8'hFF;
               ti_r   <= '0;
               if (START) begin
                  err_r     <= (OP == OP_RSVD);
                  mis_r     <= '0;
                  pattern_r <= PATTERN;
                  src_ptr   <= SRC;
                  dst_ptr   <= DST;
                  remaining <= LEN - 16'd1;
                  rd_pend   <= 1'b0;
                  if ((OP == OP_RSVD) || (LEN == 16'd0)) begin
                     state  <= S_FIN;
                     done_r <= 1'b1;
                  end else begin
                     busy_r <= 1'b1;
                     act_r  <= 1'b1;
                     if (OP == OP_FILL) begin
                        state  <= S_FILL;
                        cmd_r  <= 1'b0;
                        addr_r <= DST;
                        be_r   <= 8'h00;
                        di_r   <= PATTERN;
                     end else begin
                        state  <= (OP == OP_COPY) ? S_COPY_RD : S_CHK;
                        cmd_r  <= 1'b1;
                        addr_r <= SRC;
                        ti_r   <= rd_tag(SRC);
                     end
                  end
               end
            end

            S_FILL: begin
               if (last_word) begin
                  state  <= S_FIN;
                  done_r <= 1'b1;
                  busy_r <= 1'b0;
                  act_r  <= 1'b0;
                  be_r   <= 8'hFF;
               end else begin
                  dst_ptr   <= dst_nxt;
                  addr_r    <= dst_nxt;
                  remaining <= remaining - 16'd1;
               end
            end

            S_COPY_RD: begin
               state  <= S_COPY_WR;
               cmd_r  <= 1'b0;
               addr_r <= dst_ptr;
               be_r   <= 8'h00;
               ti_r   <= '0;
            end

            S_COPY_WR: begin
               if (!rsp_ok || last_word) begin
                  if (!rsp_ok) begin
                     err_r <= 1'b1;
                  end
                  state  <= S_FIN;
                  done_r <= 1'b1;
                  busy_r <= 1'b0;
                  act_r  <= 1'b0;
                  be_r   <= 8'hFF;
               end else begin
                  state     <= S_COPY_RD;
                  src_ptr   <= src_nxt;
                  dst_ptr   <= dst_nxt;
                  remaining <= remaining - 16'd1;
                  cmd_r     <= 1'b1;
                  addr_r    <= src_nxt;
                  be_r      <= 8'hFF;
                  ti_r      <= rd_tag(src_nxt);
               end
            end

            S_CHK: begin
               rd_pend <= 1'b1;
               rd_addr <= src_ptr;
               if (last_word) begin
                  state <= S_CHK_DRAIN;
                  act_r <= 1'b0;
                  cmd_r <= 1'b0;
                  ti_r  <= '0;
               end else begin
                  src_ptr   <= src_nxt;
                  addr_r    <= src_nxt;
                  ti_r      <= rd_tag(src_nxt);
                  remaining <= remaining - 16'd1;
               end
            end

            S_CHK_DRAIN: begin
               rd_pend <= 1'b0;
               state   <= S_FIN;
               done_r  <= 1'b1;
               busy_r  <= 1'b0;
            end

            default: begin
               state  <= S_IDLE;
               busy_r <= 1'b0;
               act_r  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_block_engine.sv
module tb_mem_block_engine;

   localparam int TW   = 21;
   localparam int MAXC = 64;

   logic          CLK = 1'b0;
   logic          RESET;
   logic          START;
   logic [1:0]    OP;
   logic [14:0]   SRC;
   logic [14:0]   DST;
   logic [15:0]   LEN;
   logic [63:0]   PATTERN;
   logic          BUSY;
   logic          DONE;
   logic          ERR;
   logic [15:0]   MISMATCH;
   logic          ACT;
   logic          CMD;
   logic [14:0]   ADDR;
   logic [7:0]    BE;
   logic [63:0]   DI;
   logic [TW-1:0] TI;
   logic          DRDY;
   logic [63:0]   DO;
   logic [TW-1:0] TO;

   mem_block_engine #(.TagWidth(TW)) dut (
      .CLK(CLK), .RESET(RESET), .START(START), .OP(OP), .SRC(SRC), .DST(DST),
      .LEN(LEN), .PATTERN(PATTERN), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
      .MISMATCH(MISMATCH), .ACT(ACT), .CMD(CMD), .ADDR(ADDR), .BE(BE), .DI(DI),
      .TI(TI), .DRDY(DRDY), .DO(DO), .TO(TO)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [1:0]  op;
      logic [14:0] src;
      logic [14:0] dst;
      logic [15:0] len;
      logic [63:0] pat;
      int          drop_rd;    // n-th read of the op loses DRDY (0 = none)
      int          bad_tag;    // n-th read of the op returns a wrong tag
      int          poke;       // cycle in which START is pulsed while busy
      int          exp_done;
      logic        exp_err;
      logic [15:0] exp_mis;
   } vec_t;

   logic [63:0] mem     [0:32767];   // memory behind the port
   logic [63:0] ref_mem [0:32767];   // what that memory should hold

   logic        exp_act  [0:MAXC-1];
   logic        exp_cmd  [0:MAXC-1];
   logic [14:0] exp_addr [0:MAXC-1];
   logic [63:0] exp_di   [0:MAXC-1];

   int n_vec  = 0;
   int n_fail = 0;
   int rd_count, drop_rd_n, bad_tag_n;

   vec_t tab [0:8];

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
      n_vec++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", nm, got, want);
      end
   endtask

   function automatic logic [TW-1:0] exp_tag(input logic [14:0] a);
      return {1'b1, 5'b0, a};
   endfunction

   // Memory responder: services the request seen in a cycle, read data
   // appears from just after the following edge for one cycle.
   initial begin : responder
      logic          rd_v, drop, bad;
      logic [63:0]   rdat;
      logic [TW-1:0] rtag;
      DRDY = 1'b0;
      DO   = '0;
      TO   = '0;
      rdat = '0;
      rtag = '0;
      forever begin
         @(negedge CLK);
         rd_v = 1'b0;
         drop = 1'b0;
         bad  = 1'b0;
         if (ACT === 1'b1 && CMD === 1'b1) begin
            rd_count++;
            rd_v = 1'b1;
            rdat = mem[ADDR];
            rtag = TI;
            drop = (rd_count == drop_rd_n);
            bad  = (rd_count == bad_tag_n);
         end else if (ACT === 1'b1 && CMD === 1'b0) begin
            for (int b = 0; b < 8; b++)
               if (!BE[b]) mem[ADDR][8*b +: 8] = DI[8*b +: 8];
         end
         @(posedge CLK);
         #1;
         DRDY = rd_v && !drop;
         DO   = rdat;
         TO   = bad ? (rtag ^ TW'(1)) : rtag;
      end
   end

   // Reference: expected request per cycle after the START edge, the DONE
   // cycle, the final ERR / MISMATCH and the resulting memory contents.
   task automatic model_op(input vec_t v, output int dc, output logic er,
                           output logic [15:0] mis);
      logic [14:0] a, b;
      logic [63:0] d;
      for (int k = 0; k < MAXC; k++) begin
         exp_act[k] = 0; exp_cmd[k] = 0; exp_addr[k] = 0; exp_di[k] = 0;
      end
      er = 0; mis = 0; dc = 1;
      if (v.op == 2'd3) begin
         er = 1;
      end else if (v.len != 0) begin
         if (v.op == 2'd0) begin
            dc = int'(v.len) + 1;
            for (int w = 0; w < int'(v.len); w++) begin
               a = v.dst + 15'(w);
               exp_act[w+1] = 1; exp_addr[w+1] = a; exp_di[w+1] = v.pat;
               ref_mem[a] = v.pat;
            end
         end else if (v.op == 2'd1) begin
            dc = 2 * int'(v.len) + 1;
            for (int w = 0; w < int'(v.len); w++) begin
               a = v.src + 15'(w);
               b = v.dst + 15'(w);
               exp_act[2*w+1] = 1; exp_cmd[2*w+1] = 1; exp_addr[2*w+1] = a;
               if (v.drop_rd == w + 1 || v.bad_tag == w + 1) begin
                  er = 1;
                  dc = 2 * w + 3;
                  break;
               end
               d = ref_mem[a];
               exp_act[2*w+2] = 1; exp_addr[2*w+2] = b; exp_di[2*w+2] = d;
               ref_mem[b] = d;
            end
         end else begin
            dc = int'(v.len) + 2;
            for (int i = 0; i < int'(v.len); i++) begin
               a = v.src + 15'(i);
               exp_act[i+1] = 1; exp_cmd[i+1] = 1; exp_addr[i+1] = a;
               if (v.drop_rd == i + 1) begin
                  er = 1;
               end else begin
                  if (ref_mem[a] != v.pat && mis != 16'hFFFF) mis++;
                  if (v.bad_tag == i + 1) er = 1;
               end
            end
         end
      end
   endtask

   // Apply one op (expects to be entered just after a rising edge) and check
   // every cycle up to one past DONE against the reference trace.
   task automatic run_op(input int vid, input vec_t v);
      logic [14:0] a;
      drop_rd_n = v.drop_rd;
      bad_tag_n = v.bad_tag;
      rd_count  = 0;
      OP = v.op; SRC = v.src; DST = v.dst; LEN = v.len; PATTERN = v.pat;
      START = 1'b1;
      @(posedge CLK);
      #1;
      START = 1'b0;
      for (int c = 1; c <= v.exp_done + 1 && c < MAXC; c++) begin
         @(negedge CLK);
         chk($sformatf("v%0d c%0d act", vid, c), ACT, exp_act[c]);
         if (exp_act[c]) begin
            chk($sformatf("v%0d c%0d cmd", vid, c), CMD, exp_cmd[c]);
            chk($sformatf("v%0d c%0d addr", vid, c), ADDR, exp_addr[c]);
            if (exp_cmd[c]) begin
               chk($sformatf("v%0d c%0d tag", vid, c), TI, exp_tag(exp_addr[c]));
            end else begin
               chk($sformatf("v%0d c%0d be", vid, c), BE, 8'h00);
               chk($sformatf("v%0d c%0d wdata", vid, c), DI, exp_di[c]);
               chk($sformatf("v%0d c%0d wtag", vid, c), TI, '0);
            end
         end
         chk($sformatf("v%0d c%0d done", vid, c), DONE, (c == v.exp_done));
         chk($sformatf("v%0d c%0d busy", vid, c), BUSY, (c < v.exp_done));
         if (c == v.exp_done) begin
            chk($sformatf("v%0d err", vid), ERR, v.exp_err);
            chk($sformatf("v%0d miscount", vid), MISMATCH, v.exp_mis);
         end
         if (v.poke != 0 && c == v.poke) begin
            START = 1'b1; OP = 2'b11; LEN = 16'd1;
         end else if (v.poke != 0 && c == v.poke + 1) begin
            START = 1'b0; OP = v.op; LEN = v.len;
         end
      end
      START = 1'b0;
      @(posedge CLK);
      #1;
      if ((v.op == 2'd0 || v.op == 2'd1) && v.len != 0) begin
         for (int w = 0; w < int'(v.len); w++) begin
            a = v.dst + 15'(w);
            chk($sformatf("v%0d readback %0h", vid, a), mem[a], ref_mem[a]);
         end
      end
   endtask

   initial begin : watchdog
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : main
      int          dc;
      logic        e_err;
      logic [15:0] e_mis;
      vec_t        v;
      logic [14:0] a;
      logic [63:0] val;

      //          op     src       dst       len     pat                    drop bad poke done err   mis
      tab[0] = '{2'd2, 15'h0000, 15'h0000, 16'd8, 64'h0,                  0,   0,  3,  10,  1'b0, 16'd2};
      tab[1] = '{2'd1, 15'h0010, 15'h0100, 16'd3, 64'h0,                  0,   0,  2,  7,   1'b0, 16'd0};
      tab[2] = '{2'd0, 15'h0000, 15'h7FFE, 16'd4, 64'h0123456789ABCDEF,   0,   0,  2,  5,   1'b0, 16'd0};
      tab[3] = '{2'd0, 15'h0000, 15'h0500, 16'd0, 64'h5555,               0,   0,  0,  1,   1'b0, 16'd0};
      tab[4] = '{2'd1, 15'h0010, 15'h0500, 16'd0, 64'h0,                  0,   0,  0,  1,   1'b0, 16'd0};
      tab[5] = '{2'd2, 15'h0000, 15'h0000, 16'd0, 64'h0,                  0,   0,  0,  1,   1'b0, 16'd0};
      tab[6] = '{2'd3, 15'h0010, 15'h0500, 16'd5, 64'h0,                  0,   0,  0,  1,   1'b1, 16'd0};
      tab[7] = '{2'd1, 15'h0300, 15'h0400, 16'd3, 64'h0,                  2,   0,  1,  5,   1'b1, 16'd0};
      tab[8] = '{2'd2, 15'h0200, 15'h0000, 16'd6, 64'h0,                  0,   3,  4,  8,   1'b1, 16'd0};

      RESET = 1'b0; START = 1'b0; OP = '0; SRC = '0; DST = '0; LEN = '0; PATTERN = '0;
      drop_rd_n = 0; bad_tag_n = 0; rd_count = 0;
      for (int i = 0; i < 32768; i++) begin
         mem[i] = '0;
         ref_mem[i] = '0;
      end
      mem[15'h0002] = 64'hDEAD_BEEF_0000_0002; ref_mem[15'h0002] = 64'hDEAD_BEEF_0000_0002;
      mem[15'h0005] = 64'h0000_0000_0000_0500; ref_mem[15'h0005] = 64'h0000_0000_0000_0500;
      mem[15'h0010] = 64'hAAAA_1111_2222_3333;  ref_mem[15'h0010] = 64'hAAAA_1111_2222_3333;
      mem[15'h0011] = 64'hBBBB_4444_5555_6666;  ref_mem[15'h0011] = 64'hBBBB_4444_5555_6666;
      mem[15'h0012] = 64'hCCCC_7777_8888_9999;  ref_mem[15'h0012] = 64'hCCCC_7777_8888_9999;
      mem[15'h0300] = 64'h0300_0300_0300_0300;  ref_mem[15'h0300] = 64'h0300_0300_0300_0300;
      mem[15'h0301] = 64'h0301_0301_0301_0301;  ref_mem[15'h0301] = 64'h0301_0301_0301_0301;
      mem[15'h0302] = 64'h0302_0302_0302_0302;  ref_mem[15'h0302] = 64'h0302_0302_0302_0302;

      repeat (3) @(negedge CLK);
      chk("reset act", ACT, 1'b0);
      chk("reset cmd", CMD, 1'b0);
      chk("reset addr", ADDR, 15'h0);
      chk("reset be", BE, 8'hFF);
      chk("reset di", DI, 64'h0);
      chk("reset ti", TI, '0);
      chk("reset busy", BUSY, 1'b0);
      chk("reset done", DONE, 1'b0);
      chk("reset err", ERR, 1'b0);
      chk("reset miscount", MISMATCH, 16'h0);
      RESET = 1'b1;
      @(posedge CLK);
      #1;

      for (int i = 0; i < 9; i++) begin
         model_op(tab[i], dc, e_err, e_mis);
         run_op(i, tab[i]);
      end

      // Reset in the middle of a FILL, after three words went out.
      OP = 2'd0; SRC = '0; DST = 15'h1000; LEN = 16'd8; PATTERN = 64'hFEED_FACE_CAFE_F00D;
      drop_rd_n = 0; bad_tag_n = 0; rd_count = 0;
      START = 1'b1;
      @(posedge CLK);
      #1;
      START = 1'b0;
      repeat (3) @(negedge CLK);
      chk("rst-fill act before", ACT, 1'b1);
      RESET = 1'b0;
      @(negedge CLK);
      chk("rst-fill act", ACT, 1'b0);
      chk("rst-fill busy", BUSY, 1'b0);
      chk("rst-fill be", BE, 8'hFF);
      chk("rst-fill done", DONE, 1'b0);
      chk("rst-fill err", ERR, 1'b0);
      RESET = 1'b1;
      repeat (3) begin
         @(negedge CLK);
         chk("rst-fill no done", DONE, 1'b0);
         chk("rst-fill idle act", ACT, 1'b0);
      end
      for (int w = 0; w < 3; w++) ref_mem[15'h1000 + 15'(w)] = 64'hFEED_FACE_CAFE_F00D;
      for (int w = 0; w < 5; w++) begin
         a = 15'h1000 + 15'(w);
         chk($sformatf("rst-fill mem %0h", a), mem[a], ref_mem[a]);
      end
      @(posedge CLK);
      #1;
      v = '{2'd0, 15'h0, 15'h1000, 16'd8, 64'h1234_5678_9ABC_DEF0, 0, 0, 4, 9, 1'b0, 16'd0};
      model_op(v, dc, e_err, e_mis);
      run_op(100, v);

      // Randomized ops against the reference, around the address wrap.
      for (int k = 0; k < 360; k++) begin
         a   = 15'(k) - 15'd40;
         val = ($urandom_range(0, 1) == 0) ? 64'h0 : {$urandom, $urandom};
         mem[a] = val;
         ref_mem[a] = val;
      end
      for (int n = 0; n < 40; n++) begin
         int r;
         r = $urandom_range(0, 9);
         v.op      = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
         v.len     = 16'($urandom_range(0, 12));
         v.src     = 15'($urandom_range(0, 300)) - 15'd40;
         v.dst     = 15'($urandom_range(0, 300)) - 15'd40;
         v.pat     = ($urandom_range(0, 1) == 0) ? 64'h0 : {$urandom, $urandom};
         v.drop_rd = ($urandom_range(0, 3) == 0) ? $urandom_range(1, (v.len > 0) ? int'(v.len) : 1) : 0;
         v.bad_tag = ($urandom_range(0, 3) == 0) ? $urandom_range(1, (v.len > 0) ? int'(v.len) : 1) : 0;
         model_op(v, dc, e_err, e_mis);
         v.exp_done = dc;
         v.exp_err  = e_err;
         v.exp_mis  = e_mis;
         v.poke     = (dc >= 2 && $urandom_range(0, 2) == 0) ? $urandom_range(1, dc - 1) : 0;
         run_op(200 + n, v);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
